input_conditioner: RTL
======================

Name: input_conditioner

Overview:
- Parametrised successor to the traffic-controller input synchronizer.
- Conditions N_CH asynchronous inputs (sensor, walk request, reprogram, spares) using a configurable-depth synchronizer chain, per-channel debounce, and registered rise/fall pulses.
- Channels selected by mask get a sticky request latch, which the FSM clears explicitly.
- Sits between the board pins and the traffic-light FSM / timer blocks.

Parameters:
- N_CH, 4: number of input channels.
- SYNC_STAGES, 2: flip-flops per synchronizer chain; legal values 2 to 4.
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized value must differ from level_out before level_out changes; 1 means no filtering.
- STICKY_MASK, 4'b0010: per-channel enable for the sticky request latch (bit i is channel i).
- CNT_W, max(1, clog2(DEBOUNCE_CYCLES)): derived width of the debounce counter; not overridden.

Ports:
- clock, input, 1: single system clock; all state updates on its rising edge.
- Reset, input, 1: synchronous, active-high reset. It must already be synchronous to clock; raw-pin reset conditioning is done outside this block.
- async_in, input, N_CH: raw asynchronous inputs.
- sticky_clr, input, N_CH: per-channel clear for sticky_out; synchronous to clock.
- sync_out, output, N_CH: last synchronizer stage, undebounced.
- level_out, output, N_CH: debounced level.
- rise_pulse, output, N_CH: one-cycle pulse when level_out goes 0 to 1.
- fall_pulse, output, N_CH: one-cycle pulse when level_out goes 1 to 0.
- sticky_out, output, N_CH: latched request; constant 0 on channels whose STICKY_MASK bit is 0.

Behaviour:
- Reset: while Reset is sampled 1 at a rising edge, all synchronizer stages, level_out, debounce counters, rise_pulse, fall_pulse and sticky_out clear to 0. Reset overrides every other input.
- Synchronizer:
  - Per channel, a shift chain: stage0 <= async_in[i], stage[k] <= stage[k-1].
  - sync_out is the last stage, so a new value sampled at edge E appears on sync_out after edge E+SYNC_STAGES-1.
  - No logic is placed between chain stages.
- Debounce, per channel (D = DEBOUNCE_CYCLES):
  - If sync_out == level_out: cnt <= 0.
  - If sync_out != level_out and cnt < D-1: cnt <= cnt+1.
  - If sync_out != level_out and cnt == D-1: level_out <= sync_out and cnt <= 0; this is an "update".
- Latency: a clean input step reaches level_out SYNC_STAGES + D edges after it is first sampled, counting the sampling edge. Defaults give 6 edges.
- Glitch rejection:
  - A synchronized excursion shorter than D cycles produces no level_out change, and cnt returns to 0.
  - Toggling that returns to level_out before the count completes restarts the count.
- Pulses:
  - Both pulses are registered on the same edge as the update.
  - rise_pulse[i] <= update and new value 1; fall_pulse[i] <= update and new value 0.
  - The pulse is high for exactly the first cycle of the new level_out, and low otherwise.
  - rise_pulse and fall_pulse on one channel are never high together.
- Sticky latch, channels with mask bit 1:
  - sticky_out <= (sticky_out and not sticky_clr) or rise_event, where rise_event is the update-to-1 condition on the same edge.
  - If set and clear coincide, set wins, so no request is lost.
  - sticky_clr on a masked-off channel is ignored.
- Channel independence: channels share no state; simultaneous events on different channels behave as if each occurred alone.
- Reset mid-debounce: the partial count is discarded. After reset release, an input held at 1 is treated as a fresh step with the full latency.
- Elaboration check: SYNC_STAGES < 2 or DEBOUNCE_CYCLES < 1 is a fatal error.

Test Plan:
- Reset with all inputs at 1 for 2 cycles, then release and hold async_in=4'b0000 -> every output is 0 throughout and after release.
- Defaults; async_in[0] rises just before edge 10 and stays high -> sync_out[0] high after edge 11; level_out[0] and rise_pulse[0] high after edge 15; rise_pulse[0] low after edge 16.
- Defaults; async_in[2] high for 3 cycles, then low -> sync_out[2] pulses for 3 cycles; level_out[2], rise_pulse[2] and fall_pulse[2] stay 0.
- Defaults; channel 1 (sticky) gets a clean rise then fall, with sticky_clr[1] held 0 -> sticky_out[1] sets with rise_pulse[1] and stays 1 after fall_pulse[1]. A 1-cycle sticky_clr[1] then clears it on the next edge.
- Channel 1: a second rise_event coincides with sticky_clr[1]=1 -> sticky_out[1] stays 1. Channel 0: assert sticky_clr[0] -> sticky_out[0] stays 0 throughout.
- N_CH=6, SYNC_STAGES=3, DEBOUNCE_CYCLES=1; steps applied to channels 0 and 5 on the same cycle -> both level_out bits rise 4 edges after sampling, with simultaneous rise_pulses. Then assert Reset at the midpoint of a channel-3 count -> channel 3 count restarts after release, with full latency.

Source files
------------

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
//   Conditions N_CH asynchronous board inputs for the traffic-light FSM and
//   the timer blocks. Each channel has a synchronizer chain, a debounce
//   filter and registered rise/fall pulses. Channels selected by STICKY_MASK
//   also have a request latch that the FSM clears explicitly.
//
// Ports
//   clock       : system clock, rising-edge active
//   Reset       : synchronous active-high reset (already synchronous to clock)
//   async_in    : raw asynchronous inputs, one bit per channel
//   sticky_clr  : per-channel clear for sticky_out (synchronous to clock)
//   sync_out    : last synchronizer stage, not debounced
//   level_out   : debounced level
//   rise_pulse  : one-cycle pulse on the first cycle of level_out = 1
//   fall_pulse  : one-cycle pulse on the first cycle of level_out = 0
//   sticky_out  : latched request; constant 0 on channels not in STICKY_MASK
// ---------------------------------------------------------------------------
module input_conditioner #(
  parameter int              N_CH            = 4,
  parameter int              SYNC_STAGES     = 2,
  parameter int              DEBOUNCE_CYCLES = 4,
  parameter logic [N_CH-1:0] STICKY_MASK     = N_CH'(4'b0010)
) (
  input  logic            clock,
  input  logic            Reset,
  input  logic [N_CH-1:0] async_in,
  input  logic [N_CH-1:0] sticky_clr,
  output logic [N_CH-1:0] sync_out,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] sticky_out
);

  // A one-bit counter is kept even when no filtering is configured so the
  // debounce logic stays uniform.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $fatal(1, "input_conditioner: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] chain_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   level_reg;
    logic                   rise_reg;
    logic                   fall_reg;
    logic                   sync_bit;
    logic                   differ;
    logic                   update;

    assign sync_bit = chain_reg[SYNC_STAGES-1];
    assign differ   = sync_bit ^ level_reg;
    // The level changes on the edge where the mismatch has already been
    // seen for DEBOUNCE_CYCLES-1 earlier edges.
    assign update   = differ && (cnt_reg == CNT_MAX);

    always_ff @(posedge clock) begin
      if (Reset) begin
        chain_reg <= '0;
        cnt_reg   <= '0;
        level_reg <= 1'b0;
        rise_reg  <= 1'b0;
        fall_reg  <= 1'b0;
      end else begin
        // Pure shift chain: nothing between stages, so every stage has a
        // full cycle to settle out of metastability.
        chain_reg <= {chain_reg[SYNC_STAGES-2:0], async_in[gi]};

        // Any return to the current level discards the partial count, so
        // toggling input restarts the filter.
        if (!differ) begin
          cnt_reg <= '0;
        end else if (update) begin
          level_reg <= sync_bit;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end

        rise_reg <= update &  sync_bit;
        fall_reg <= update & ~sync_bit;
      end
    end

    assign sync_out[gi]   = sync_bit;
    assign level_out[gi]  = level_reg;
    assign rise_pulse[gi] = rise_reg;
    assign fall_pulse[gi] = fall_reg;

    if (STICKY_MASK[gi]) begin : g_sticky
      logic sticky_reg;

      // The set term is ORed in after the clear so a request arriving on
      // the same edge as a clear is never lost.
      always_ff @(posedge clock) begin
        if (Reset) begin
          sticky_reg <= 1'b0;
        end else begin
          sticky_reg <= (sticky_reg & ~sticky_clr[gi]) | (update & sync_bit);
        end
      end

      assign sticky_out[gi] = sticky_reg;
    end else begin : g_no_sticky
      // Clear input has no function on channels without a latch.
      logic unused_clr;
      assign unused_clr     = sticky_clr[gi];
      assign sticky_out[gi] = 1'b0;
    end
  end

endmodule
